ins_mem_loader: RTL
===================

# ins_mem_loader

Byte-stream loader that sits directly upstream of the instruction memory. It receives a program image as a stream of bytes from the serial receiver and assembles the bytes into DATA_WIDTH-bit instruction words. It writes the words into consecutive memory locations starting at address 0 through the memory's write port (write enable, address, data). It then raises a completion flag that releases the processor cores from reset-hold.

## Interface
- DATA_WIDTH, 12: instruction word width; must be 9..16 (two bytes per word).
- DEPTH, 256: instruction memory depth in words.
- ADDR_WIDTH, $clog2(DEPTH): memory address width.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms loader from IDLE, ignored elsewhere.
- rxData  in  8  incoming byte.
- rxValid  in  1  rxData valid this cycle.
- rxReady  out  1  loader accepts byte; a transfer occurs when rxValid && rxReady.
- wrEn  out  1  memory write strobe, one cycle per word.
- address  out  ADDR_WIDTH  memory write address.
- dataOut  out  DATA_WIDTH  word to memory.
- busy  out  1  load in progress (any state except IDLE/DONE).
- loadDone  out  1  image fully written; held until next start or rst.
- err  out  1  load failed; held until next start or rst.

## Operation
- Frame: CNT_LO, CNT_HI (16-bit word count N, little-endian), then N words as LO byte, HI byte; with checksum, one trailing checksum byte.
- Word = {HI[DATA_WIDTH-9:0], LO}; unused HI bits discarded.
- FSM states: IDLE, CNT_LO, CNT_HI, DAT_LO, DAT_HI, WRITE, CHK (macro only), DONE.
- IDLE: rxReady=0; start -> CNT_LO, clears loadDone, err, address, word counter.
- CNT_LO/CNT_HI: accept one byte each; after CNT_HI, N==0 or N>DEPTH -> err=1, go to IDLE, with no writes; else -> DAT_LO.
- DAT_LO: latch low byte -> DAT_HI. DAT_HI: latch high byte -> WRITE.
- WRITE: rxReady=0; wrEn=1 with address/dataOut stable; next cycle address+1, counter+1; if counter reaches N -> CHK (or DONE), else -> DAT_LO.
- Address never wraps: N<=DEPTH guarantees the last write is at DEPTH-1; address holds the final written address + 1 mod 2^ADDR_WIDTH (don't-care).
- DONE: rxReady=0, loadDone=1; start -> CNT_LO (reload); bytes offered in DONE/IDLE are not consumed.
- start in any state other than IDLE/DONE: ignored.
- rst at any time: abort immediately; no further wrEn; partially written memory is left as is.

## Timing
- Reset values: rxReady=0, wrEn=0, address=0, dataOut=0, busy=0, loadDone=0, err=0, state IDLE.
- rxReady is registered from state: 1 in CNT_LO, CNT_HI, DAT_LO, DAT_HI, CHK.
- wrEn asserts the cycle after the HI byte handshake; exactly one cycle wide.
- Max throughput: one word per 3 cycles (LO, HI, WRITE), given continuous rxValid.
- loadDone rises the cycle after the final WRITE (no checksum) or after the checksum byte handshake.
- busy=1 from the cycle after start until the cycle loadDone or err rises.
- rxValid gaps stall the FSM in the current receive state indefinitely; no timeout.

## Configuration
- LOADER_CHECKSUM_EN defined: running 8-bit XOR over all accepted bytes (count and data); CHK state accepts one byte; on mismatch, err=1 and loadDone=1 (image written but flagged); on match, loadDone=1 and err=0.
- Undefined: no CHK state and no XOR register; the WRITE of the last word goes straight to DONE; err only from an invalid count.

## Structure
- Shared package: FSM state enum, LOADER_BYTE_W=8 constant, count-field width (16).
- One natural sub-module: loader_word_asm (two-byte -> DATA_WIDTH word assembly plus optional XOR accumulator); the FSM and counters stay in the top level.

## Test plan
- Load N=3, words 0x123,0x456,0x789 (bytes 03 00 23 01 56 04 89 07) -> wrEn at addr 0,1,2 with those data; loadDone=1; err=0.
- Count 00 00, then count 01 01 (257>DEPTH) -> err=1, no wrEn, return to IDLE, rxReady=0.
- N=256 contiguous stream -> 256 writes, last at address 255; loadDone after the last write.
- rxValid toggled randomly during N=2 -> same writes, stall cycles only; rst asserted mid-word -> wrEn never pulses after reset; all outputs at reset values.
- LOADER_CHECKSUM_EN, N=1, word 0x0AB (bytes 01 00 AB 00), checksum AA -> loadDone=1, err=0; checksum 00 -> loadDone=1, err=1.
- start pulsed while busy -> ignored; start in DONE -> new load from address 0, loadDone cleared the next cycle.

Source files
------------

// File: rtl/ins_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
// Used by ins_mem_loader, its interface and the loader_word_asm sub-module.
package ins_mem_loader_pkg;

  localparam int LOADER_BYTE_W = 8;
  localparam int LOADER_CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_CNT_HI = 3'd2,
    S_DAT_LO = 3'd3,
    S_DAT_HI = 3'd4,
    S_WRITE  = 3'd5,
    S_CHK    = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  function automatic logic rx_ready_for(input state_t s);
    case (s)
      S_CNT_LO, S_CNT_HI, S_DAT_LO, S_DAT_HI, S_CHK: rx_ready_for = 1'b1;
      default:                                       rx_ready_for = 1'b0;
    endcase
  endfunction

  function automatic logic busy_for(input state_t s);
    busy_for = (s != S_IDLE) && (s != S_DONE);
  endfunction

endpackage

// File: rtl/ins_mem_loader_if.sv
// Byte-stream receive port plus instruction-memory write port of the loader.
// master = loader side, slave = receiver/memory side.
interface ins_mem_loader_if
  import ins_mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 8
);
  logic [LOADER_BYTE_W-1:0] rxData;
  logic                     rxValid;
  logic                     rxReady;
  logic                     wrEn;
  logic [ADDR_WIDTH-1:0]    address;
  logic [DATA_WIDTH-1:0]    dataOut;

  modport master (
    input  rxData, rxValid,
    output rxReady, wrEn, address, dataOut
  );

  modport slave (
    output rxData, rxValid,
    input  rxReady, wrEn, address, dataOut
  );
endinterface

// File: rtl/ins_mem_loader_word_asm.sv
// loader_word_asm: packs LO/HI bytes into one instruction word; with
// LOADER_CHECKSUM_EN it also keeps a running XOR of every accepted byte.
module loader_word_asm
  import ins_mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 12
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [LOADER_BYTE_W-1:0] i_byte,
  input  logic [DATA_WIDTH-9:0]    i_hi_bits,
  input  logic                     i_lo_en,
  input  logic                     i_hi_en,
  output logic [DATA_WIDTH-1:0]    o_word
`ifdef LOADER_CHECKSUM_EN
  ,
  input  logic                     i_clr,
  input  logic                     i_acc_en,
  output logic [LOADER_BYTE_W-1:0] o_xor
`endif
);

  logic [LOADER_BYTE_W-1:0] r_lo;
  logic [DATA_WIDTH-1:0]    r_word;

  // Low byte is held until its HI partner arrives; the word is then frozen for the write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lo   <= 8'h00;
      r_word <= '0;
    end else begin
      if (i_lo_en) r_lo <= i_byte;
      if (i_hi_en) r_word <= {i_hi_bits, r_lo};
    end
  end

  assign o_word = r_word;

`ifdef LOADER_CHECKSUM_EN
  logic [LOADER_BYTE_W-1:0] r_xor;

  // Running XOR over count and data bytes, restarted on every arm.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_xor <= 8'h00;
    else if (i_acc_en)  r_xor <= r_xor ^ i_byte;
    else                r_xor <= r_xor;
  end

  assign o_xor = r_xor;
`endif

endmodule

// File: rtl/ins_mem_loader.sv
// Instruction-memory loader: count header, then LO/HI word pairs written from address 0.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module ins_mem_loader
  import ins_mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  ins_mem_loader_if.master bus,
  output logic             o_busy,
  output logic             o_loadDone,
  output logic             o_err
);

  state_t r_state, w_state_nxt;
  logic                     r_rx_ready, r_wr_en, r_busy, r_load_done, r_err;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [LOADER_BYTE_W-1:0] r_cnt_lo;
  logic [LOADER_CNT_W-1:0]  r_num, r_word_cnt, w_count;
  logic                     w_xfer, w_arm, w_count_bad, w_last, w_err_set;
  logic [DATA_WIDTH-1:0]    w_word;
`ifdef LOADER_CHECKSUM_EN
  logic [LOADER_BYTE_W-1:0] w_xor;
`endif

  assign w_xfer      = bus.rxValid && r_rx_ready;
  assign w_count     = {bus.rxData, r_cnt_lo};
  assign w_count_bad = (w_count == 16'd0) || ({1'b0, w_count} > 17'(DEPTH));
  assign w_arm       = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last      = (r_word_cnt + 16'd1) == r_num;

  loader_word_asm #(.DATA_WIDTH(DATA_WIDTH)) u_word_asm (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_byte    (bus.rxData),
    .i_hi_bits (bus.rxData[DATA_WIDTH-9:0]),
    .i_lo_en   (w_xfer && (r_state == S_DAT_LO)),
    .i_hi_en   (w_xfer && (r_state == S_DAT_HI)),
    .o_word    (w_word)
`ifdef LOADER_CHECKSUM_EN
    ,
    .i_clr     (w_arm),
    .i_acc_en  (w_xfer),
    .o_xor     (w_xor)
`endif
  );

  // Next-state decode; w_err_set flags a bad count or checksum mismatch.
  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) w_state_nxt = S_CNT_LO;
        else         w_state_nxt = r_state;
      end
      S_CNT_LO: begin
        if (w_xfer) w_state_nxt = S_CNT_HI;
        else        w_state_nxt = S_CNT_LO;
      end
      S_CNT_HI: begin
        if (w_xfer && w_count_bad) begin
          w_state_nxt = S_IDLE;
          w_err_set   = 1'b1;
        end else if (w_xfer) begin
          w_state_nxt = S_DAT_LO;
        end else begin
          w_state_nxt = S_CNT_HI;
        end
      end
      S_DAT_LO: begin
        if (w_xfer) w_state_nxt = S_DAT_HI;
        else        w_state_nxt = S_DAT_LO;
      end
      S_DAT_HI: begin
        if (w_xfer) w_state_nxt = S_WRITE;
        else        w_state_nxt = S_DAT_HI;
      end
      S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_last) w_state_nxt = S_CHK;
`else
        if (w_last) w_state_nxt = S_DONE;
`endif
        else        w_state_nxt = S_DAT_LO;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_xfer) begin
          w_state_nxt = S_DONE;
          w_err_set   = (bus.rxData != w_xor);
        end else begin
          w_state_nxt = S_CHK;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters and outputs; strobes are registered from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rx_ready  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_cnt_lo    <= 8'h00;
      r_num       <= 16'd0;
      r_word_cnt  <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_rx_ready  <= rx_ready_for(w_state_nxt);
      r_wr_en     <= (w_state_nxt == S_WRITE);
      r_busy      <= busy_for(w_state_nxt);
      r_load_done <= (w_state_nxt == S_DONE);
      if (w_arm)          r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
      if (w_arm) begin
        r_addr     <= '0;
        r_word_cnt <= 16'd0;
      end else if (r_state == S_WRITE) begin
        r_addr     <= r_addr + ADDR_WIDTH'(1);
        r_word_cnt <= r_word_cnt + 16'd1;
      end
      if (w_xfer && (r_state == S_CNT_LO)) r_cnt_lo <= bus.rxData;
      if (w_xfer && (r_state == S_CNT_HI)) r_num <= w_count;
    end
  end

  assign bus.rxReady = r_rx_ready;
  assign bus.wrEn    = r_wr_en;
  assign bus.address = r_addr;
  assign bus.dataOut = w_word;
  assign o_busy      = r_busy;
  assign o_loadDone  = r_load_done;
  assign o_err       = r_err;

endmodule
